// File: rtl/apb_master.sv
// APB requester: accepts one valid/ready command at a time and runs it through APB SETUP/ACCESS.
// Misaligned requests are rejected without touching the bus. A stalled pready is cut off by a timeout.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                i_pclk,
  input  logic                i_preset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_strb,
  input  logic [2:0]          i_req_prot,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_psel,
  output logic                o_penable,
  output logic [ADDR_W-1:0]   o_paddr,
  output logic                o_pwrite,
  output logic [2:0]          o_pprot,
  output logic [DATA_W-1:0]   o_pwdata,
  output logic [DATA_W/8-1:0] o_pstrb,
  input  logic [DATA_W-1:0]   i_prdata,
  input  logic                i_pready,
  input  logic                i_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_psel;
  logic                r_penable;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [2:0]          r_pprot;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;

  logic w_accept;
  logic w_misaligned;

  assign w_accept     = i_req_valid && r_req_ready;
  assign w_misaligned = (i_req_addr[1:0] != 2'b00);

  // The APB output registers double as the request latch; they are only loaded for aligned requests.
  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pprot     <= 3'd0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_misaligned) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= RESP;
            end else begin
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_paddr   <= i_req_addr;
              r_pwrite  <= i_req_write;
              r_pprot   <= i_req_prot;
              r_pwdata  <= i_req_write ? i_req_wdata : '0;
              r_pstrb   <= i_req_write ? i_req_strb : '0;
              r_state   <= SETUP;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= 8'd1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready on the last allowed cycle still wins over the timeout.
          if (i_pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= i_pslverr;
            r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
            r_cnt       <= 8'd0;
            r_state     <= RESP;
          end else if (r_cnt >= TIMEOUT_CNT) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_cnt       <= 8'd0;
            r_state     <= RESP;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_paddr     = r_paddr;
  assign o_pwrite    = r_pwrite;
  assign o_pprot     = r_pprot;
  assign o_pwdata    = r_pwdata;
  assign o_pstrb     = r_pstrb;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: acts as requester and APB slave, compares against a transaction-level model.
module tb_apb_master;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        pclk = 1'b0;
  logic        preset;
  logic        reqValid, reqWrite;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqStrb;
  logic [2:0]  reqProt;
  logic        oReqReady, oRspValid, oRspErr, oPsel, oPenable, oPwrite;
  logic [31:0] oRspRdata, oPaddr, oPwdata;
  logic [3:0]  oPstrb;
  logic [2:0]  oPprot;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int total = 0;
  int bad   = 0;

  int          obsAcceptWait, obsSetup, obsAccess, obsRspCycle, obsRspCount, obsProtoBad;
  logic        obsStable, obsDropOk, obsReadyAfter, obsHold, obsErr, obsPwrite;
  logic [31:0] obsRdata, obsPaddr, obsPwdata;
  logic [3:0]  obsPstrb;
  logic [2:0]  obsPprot;

  typedef struct {
    int          setup;
    int          access;
    int          rspCycle;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .i_pclk(pclk), .i_preset(preset),
    .i_req_valid(reqValid), .o_req_ready(oReqReady), .i_req_write(reqWrite),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_strb(reqStrb), .i_req_prot(reqProt),
    .o_rsp_valid(oRspValid), .o_rsp_rdata(oRspRdata), .o_rsp_err(oRspErr),
    .o_psel(oPsel), .o_penable(oPenable), .o_paddr(oPaddr), .o_pwrite(oPwrite),
    .o_pprot(oPprot), .o_pwdata(oPwdata), .o_pstrb(oPstrb),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Transaction-level expectation; cycle 1 is the accept cycle, so a zero-wait transfer responds in cycle 4.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input int waitCycles,
                                 input logic slvErr, input logic [31:0] rd);
    exp_t e;
    if (addr[1:0] != 2'b00) begin
      e.setup = 0; e.access = 0; e.err = 1'b1; e.rdata = 32'd0;
    end else if (waitCycles < TIMEOUT) begin
      e.setup = 1; e.access = waitCycles + 1; e.err = slvErr; e.rdata = wr ? 32'd0 : rd;
    end else begin
      e.setup = 1; e.access = TIMEOUT; e.err = 1'b1; e.rdata = 32'd0;
    end
    e.rspCycle = 2 + e.setup + e.access;
    return e;
  endfunction

  // Issues one request from the current negedge, plays the slave, and records what the bus did.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot, input int waitCycles,
                               input logic slvErr, input logic [31:0] rdataVal);
    int  n;
    bit  done;
    obsAcceptWait = 0; obsSetup = 0; obsAccess = 0; obsRspCycle = 0; obsRspCount = 0; obsProtoBad = 0;
    obsStable = 1'b1; obsDropOk = 1'b0; obsReadyAfter = 1'b0; obsHold = 1'b0;
    obsRdata = 32'hxxxx_xxxx; obsErr = 1'bx;
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wdata; reqStrb = strb; reqProt = prot;
    while (!oReqReady && obsAcceptWait < 50) begin
      @(negedge pclk);
      obsAcceptWait++;
    end
    @(negedge pclk);
    reqValid = 1'b0; reqWrite = 1'($urandom); reqAddr = $urandom; reqWdata = $urandom;
    reqStrb = 4'($urandom); reqProt = 3'($urandom);
    n = 2;
    done = 0;
    while (!done && n < 80) begin
      if (oPenable && !oPsel) obsProtoBad++;
      if (oPsel && !oPenable) begin
        obsSetup++;
        obsPaddr = oPaddr; obsPwrite = oPwrite; obsPprot = oPprot; obsPwdata = oPwdata; obsPstrb = oPstrb;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end else if (oPsel && oPenable) begin
        obsAccess++;
        if (oPaddr !== obsPaddr || oPwrite !== obsPwrite || oPprot !== obsPprot ||
            oPwdata !== obsPwdata || oPstrb !== obsPstrb) obsStable = 1'b0;
        if (obsAccess == waitCycles + 1) begin
          pready = 1'b1; pslverr = slvErr; prdata = rdataVal;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        end
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
      if (oRspValid) begin
        obsRspCount++;
        if (obsRspCycle == 0) begin
          obsRspCycle = n; obsRdata = oRspRdata; obsErr = oRspErr;
        end
      end
      if (obsRspCycle != 0 && n == obsRspCycle + 1) begin
        obsDropOk     = !oRspValid;
        obsReadyAfter = oReqReady;
        obsHold       = (oRspRdata === obsRdata) && (oRspErr === obsErr);
        done = 1;
      end
      if (!done) begin
        @(negedge pclk);
        n++;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; reqStrb = '0;
    reqProt = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge pclk);
    total++; if (oReqReady !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", oReqReady); end
    total++; if ({oPsel, oPenable, oRspValid, oRspErr, oPwrite} !== 5'b0) begin bad++;
      $display("[TB] FAIL rst_ctrl: got %b want 00000", {oPsel, oPenable, oRspValid, oRspErr, oPwrite}); end
    total++; if ({oRspRdata, oPaddr, oPwdata, oPstrb, oPprot} !== '0) begin bad++;
      $display("[TB] FAIL rst_data: got %h want 0", {oRspRdata, oPaddr, oPwdata, oPstrb, oPprot}); end
    preset = 1'b0;
    @(negedge pclk);
    total++; if (oReqReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready: got %b want 1", oReqReady); end
  endtask

  task automatic test_write();
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 0, 1'b0, 32'hA5A5A5A5);
    total++; if (obsSetup !== 1) begin bad++; $display("[TB] FAIL wr_setup: got %0d want 1", obsSetup); end
    total++; if (obsAccess !== 1) begin bad++; $display("[TB] FAIL wr_access: got %0d want 1", obsAccess); end
    total++; if (obsRspCycle !== 4) begin bad++; $display("[TB] FAIL wr_rsp_cycle: got %0d want 4", obsRspCycle); end
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL wr_err: got %b want 0", obsErr); end
    total++; if (obsRdata !== 32'd0) begin bad++; $display("[TB] FAIL wr_rdata: got %h want 0", obsRdata); end
    total++; if ({obsPaddr, obsPwrite, obsPprot, obsPwdata, obsPstrb} !== {32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF}) begin bad++;
      $display("[TB] FAIL wr_bus: got %h want %h", {obsPaddr, obsPwrite, obsPprot, obsPwdata, obsPstrb},
               {32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF}); end
    total++; if (obsDropOk !== 1'b1) begin bad++; $display("[TB] FAIL wr_pulse_width: got %b want 1", obsDropOk); end
  endtask

  task automatic test_read_wait();
    applyStimulus(1'b0, 32'h04, 32'hFFFFFFFF, 4'hF, 3'd0, 3, 1'b0, 32'h12345678);
    total++; if (obsAccess !== 4) begin bad++; $display("[TB] FAIL rd_access: got %0d want 4", obsAccess); end
    total++; if (obsStable !== 1'b1) begin bad++; $display("[TB] FAIL rd_stable: got %b want 1", obsStable); end
    total++; if ({obsPwdata, obsPstrb} !== 36'd0) begin bad++; $display("[TB] FAIL rd_wdata_strb: got %h want 0", {obsPwdata, obsPstrb}); end
    total++; if (obsRdata !== 32'h12345678) begin bad++; $display("[TB] FAIL rd_rdata: got %h want 12345678", obsRdata); end
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL rd_err: got %b want 0", obsErr); end
    total++; if (obsRspCycle !== 7) begin bad++; $display("[TB] FAIL rd_rsp_cycle: got %0d want 7", obsRspCycle); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 32'h20, 32'h0BADF00D, 4'h3, 3'd1, 1, 1'b1, 32'h0);
    total++; if (obsErr !== 1'b1) begin bad++; $display("[TB] FAIL slverr_err: got %b want 1", obsErr); end
    total++; if (obsRdata !== 32'd0) begin bad++; $display("[TB] FAIL slverr_rdata: got %h want 0", obsRdata); end
    total++; if (obsReadyAfter !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready: got %b want 1", obsReadyAfter); end
    total++; if (obsHold !== 1'b1) begin bad++; $display("[TB] FAIL slverr_hold: got %b want 1", obsHold); end
    applyStimulus(1'b0, 32'h24, 32'h0, 4'h0, 3'd0, 0, 1'b1, 32'hCAFE0001);
    total++; if (obsAcceptWait !== 0) begin bad++; $display("[TB] FAIL b2b_accept_wait: got %0d want 0", obsAcceptWait); end
    total++; if ({obsErr, obsRdata} !== {1'b1, 32'hCAFE0001}) begin bad++;
      $display("[TB] FAIL rd_slverr_rsp: got %h want %h", {obsErr, obsRdata}, {1'b1, 32'hCAFE0001}); end
  endtask

  task automatic test_timeout();
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 3'd4, NEVER, 1'b0, 32'h0);
    total++; if (obsAccess !== TIMEOUT) begin bad++; $display("[TB] FAIL to_access: got %0d want %0d", obsAccess, TIMEOUT); end
    total++; if ({obsErr, obsRdata} !== {1'b1, 32'd0}) begin bad++; $display("[TB] FAIL to_rsp: got %h want 100000000", {obsErr, obsRdata}); end
    total++; if (obsRspCycle !== TIMEOUT + 3) begin bad++; $display("[TB] FAIL to_rsp_cycle: got %0d want %0d", obsRspCycle, TIMEOUT + 3); end
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0, 3'd0, TIMEOUT - 1, 1'b0, 32'h5555AAAA);
    total++; if (obsAccess !== TIMEOUT) begin bad++; $display("[TB] FAIL to_edge_access: got %0d want %0d", obsAccess, TIMEOUT); end
    total++; if ({obsErr, obsRdata} !== {1'b0, 32'h5555AAAA}) begin bad++; $display("[TB] FAIL to_edge_rsp: got %h want 05555aaaa", {obsErr, obsRdata}); end
  endtask

  task automatic test_misaligned();
    applyStimulus(1'b0, 32'h3, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h77777777);
    total++; if (obsSetup + obsAccess !== 0) begin bad++; $display("[TB] FAIL mis_psel: got %0d want 0", obsSetup + obsAccess); end
    total++; if (obsRspCycle !== 2) begin bad++; $display("[TB] FAIL mis_rsp_cycle: got %0d want 2", obsRspCycle); end
    total++; if ({obsErr, obsRdata} !== {1'b1, 32'd0}) begin bad++; $display("[TB] FAIL mis_rsp: got %h want 100000000", {obsErr, obsRdata}); end
    applyStimulus(1'b1, 32'h102, 32'h12121212, 4'hF, 3'd0, 0, 1'b0, 32'h0);
    total++; if (obsSetup + obsAccess !== 0) begin bad++; $display("[TB] FAIL mis2_psel: got %0d want 0", obsSetup + obsAccess); end
    total++; if (obsErr !== 1'b1) begin bad++; $display("[TB] FAIL mis2_err: got %b want 1", obsErr); end
  endtask

  task automatic test_reset_mid();
    bit rspSeen;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h80; reqProt = 3'd0; pready = 1'b0;
    @(negedge pclk);
    reqValid = 1'b0;
    repeat (3) @(negedge pclk);
    total++; if ({oPsel, oPenable} !== 2'b11) begin bad++; $display("[TB] FAIL mid_in_access: got %b want 11", {oPsel, oPenable}); end
    preset = 1'b1;
    @(negedge pclk);
    total++; if ({oPsel, oPenable, oRspValid, oReqReady} !== 4'b0) begin bad++;
      $display("[TB] FAIL mid_reset_outputs: got %b want 0000", {oPsel, oPenable, oRspValid, oReqReady}); end
    preset = 1'b0;
    @(negedge pclk);
    total++; if (oReqReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready_after: got %b want 1", oReqReady); end
    rspSeen = oRspValid;
    repeat (3) begin
      pready = 1'b1;
      @(negedge pclk);
      rspSeen |= oRspValid;
    end
    pready = 1'b0;
    total++; if (rspSeen !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_rsp: got %b want 0", rspSeen); end
    applyStimulus(1'b0, 32'h84, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'h89ABCDEF);
    total++; if ({obsErr, obsRdata} !== {1'b0, 32'h89ABCDEF}) begin bad++; $display("[TB] FAIL mid_next_rd: got %h want 089abcdef", {obsErr, obsRdata}); end
  endtask

  task automatic test_random();
    exp_t        e;
    logic        wr, se;
    logic [31:0] addr, wd, rd;
    logic [3:0]  st;
    logic [2:0]  pr;
    int          w;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); se = 1'($urandom); wd = $urandom; rd = $urandom; st = 4'($urandom); pr = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      w = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT + 2));
      e = model(wr, addr, w, se, rd);
      applyStimulus(wr, addr, wd, st, pr, w, se, rd);
      total++; if (obsAccess !== e.access || obsSetup !== e.setup) begin bad++;
        $display("[TB] FAIL rnd%0d_phases: got setup=%0d access=%0d want setup=%0d access=%0d", i, obsSetup, obsAccess, e.setup, e.access); end
      total++; if (obsRspCycle !== e.rspCycle) begin bad++; $display("[TB] FAIL rnd%0d_rsp_cycle: got %0d want %0d", i, obsRspCycle, e.rspCycle); end
      total++; if ({obsErr, obsRdata} !== {e.err, e.rdata}) begin bad++;
        $display("[TB] FAIL rnd%0d_rsp: got err=%b rdata=%h want err=%b rdata=%h", i, obsErr, obsRdata, e.err, e.rdata); end
      total++; if (obsRspCount !== 1 || obsDropOk !== 1'b1 || obsReadyAfter !== 1'b1 || obsHold !== 1'b1) begin bad++;
        $display("[TB] FAIL rnd%0d_handshake: got count=%0d drop=%b ready=%b hold=%b want 1 1 1 1", i, obsRspCount, obsDropOk, obsReadyAfter, obsHold); end
      total++; if (obsProtoBad !== 0) begin bad++; $display("[TB] FAIL rnd%0d_penable_wo_psel: got %0d want 0", i, obsProtoBad); end
      if (e.setup == 1) begin
        total++; if ({obsPaddr, obsPwrite, obsPprot, obsPwdata, obsPstrb} !== {addr, wr, pr, wr ? wd : 32'd0, wr ? st : 4'd0}) begin bad++;
          $display("[TB] FAIL rnd%0d_bus: got %h want %h", i, {obsPaddr, obsPwrite, obsPprot, obsPwdata, obsPstrb},
                   {addr, wr, pr, wr ? wd : 32'd0, wr ? st : 4'd0}); end
        total++; if (obsStable !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_stable: got %b want 1", i, obsStable); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
